if_fetch_unit: RTL and testbench

//  Instruction fetch stage: owns the PC, issues word reads to instruction memory over a req/ack

---
 rtl/if_fetch_unit_if.sv | 10 +
 rtl/if_fetch_unit.sv | 131 +++++++++++++
 tb/tb_if_fetch_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port: a single outstanding word read over a req/ack handshake.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, fetches over a req/ack port and feeds IF/ID through an output slot plus skid.
// Optional ack watchdog (fetch_error, retry) is enabled by defining IF_FETCH_TIMEOUT_EN.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter logic [15:0] PC_INC         = 16'd1,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            branch_taken,
    input  logic [15:0]     branch_target,
    if_fetch_unit_if.master imem,
    output logic [15:0]     instruction_out,
    output logic [15:0]     instr_addr_out,
    output logic            fetch_valid,
    output logic            if_flush,
    output logic            fetch_error
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t      state, state_next;
    logic [15:0] pc, drain_addr, skid_data, skid_addr;
    logic        req, ack, req_done, slot_free, redirect, gap, timeout_hit;

    assign slot_free = !fetch_valid || pc_write;
    assign redirect  = branch_taken && (state != S_IDLE);
    assign ack       = imem.imem_ack && req;
    // The current request is finished after this cycle: answered, withdrawn, or never issued.
    assign req_done  = ack || timeout_hit || !req;
    assign if_flush  = branch_taken;
    assign imem.imem_req = req;

`ifdef IF_FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_count;

    assign timeout_hit = req && !ack && (wd_count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_count    <= '0;
            gap         <= 1'b0;
            fetch_error <= 1'b0;
        end else begin
            gap <= timeout_hit;
            if (timeout_hit) fetch_error <= 1'b1;
            if (!req || ack || timeout_hit || state_next != state) wd_count <= '0;
            else                                                   wd_count <= wd_count + 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
    assign gap            = 1'b0;
    assign fetch_error    = 1'b0;
`endif

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  state_next = S_WAIT;
            S_WAIT: begin
                if (redirect)               state_next = req_done ? S_WAIT : S_DRAIN;
                else if (ack && !slot_free) state_next = S_HOLD;
            end
            S_HOLD:  if (redirect || pc_write) state_next = S_WAIT;
            S_DRAIN: if (ack || timeout_hit)   state_next = S_WAIT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req            = 1'b0;
        imem.imem_addr = pc;
        unique case (state)
            S_WAIT:  req = !gap;
            S_DRAIN: begin
                req            = 1'b1;
                imem.imem_addr = drain_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc              <= RESET_PC;
            drain_addr      <= '0;
            skid_data       <= '0;
            skid_addr       <= '0;
            instruction_out <= '0;
            instr_addr_out  <= '0;
            fetch_valid     <= 1'b0;
        end else if (redirect) begin
            pc              <= branch_target;
            instruction_out <= '0;
            instr_addr_out  <= '0;
            fetch_valid     <= 1'b0;
            if (state == S_WAIT && !req_done) drain_addr <= pc;
        end else if (state == S_WAIT && ack) begin
            pc <= pc + PC_INC;
            if (slot_free) begin
                instruction_out <= imem.imem_rdata;
                instr_addr_out  <= pc;
                fetch_valid     <= 1'b1;
            end else begin
                skid_data <= imem.imem_rdata;
                skid_addr <= pc;
            end
        end else if (state == S_HOLD) begin
            if (pc_write) begin
                instruction_out <= skid_data;
                instr_addr_out  <= skid_addr;
                fetch_valid     <= 1'b1;
            end
        end else if (fetch_valid && pc_write) begin
            instruction_out <= '0;
            instr_addr_out  <= '0;
            fetch_valid     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios and a randomized run checked against an in-order
// instruction-stream model with a variable-latency memory responder.
`timescale 1ns/1ps
module tb_if_fetch_unit;
    localparam int TIMEOUT = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        pc_write, branch_taken;
    logic [15:0] branch_target;
    logic [15:0] instruction_out, instr_addr_out;
    logic        fetch_valid, if_flush, fetch_error;
    logic [15:0] w_instr, w_addr;
    logic        w_valid, w_flush, w_error;

    int          checks = 0;
    int          errors = 0;

    logic [15:0] exp_addr;
    int          consumed = 0;
    int          lat_lo, lat_hi, mem_lat, mem_wait;
    logic [15:0] mem_addr_q;
    bit          stall_prev, pend_prev;
    bit          pw_r, br_r;
    logic [15:0] wrap_exp [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};

    if_fetch_unit_if bus  ();
    if_fetch_unit_if wbus ();

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    always #5 clock = ~clock;

    if_fetch_unit #(.RESET_PC(16'h0000), .PC_INC(16'd1), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .pc_write(pc_write), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem(bus), .instruction_out(instruction_out),
        .instr_addr_out(instr_addr_out), .fetch_valid(fetch_valid), .if_flush(if_flush),
        .fetch_error(fetch_error));

    // Wrap-around instance: free-running, zero-latency memory, never stalled.
    if_fetch_unit #(.RESET_PC(16'hFFFE), .PC_INC(16'd1), .TIMEOUT_CYCLES(TIMEOUT)) dut_wrap (
        .clock(clock), .reset(reset), .pc_write(1'b1), .branch_taken(1'b0),
        .branch_target(16'h0000), .imem(wbus), .instruction_out(w_instr),
        .instr_addr_out(w_addr), .fetch_valid(w_valid), .if_flush(w_flush),
        .fetch_error(w_error));

    assign wbus.imem_ack   = wbus.imem_req;
    assign wbus.imem_rdata = mem_word(wbus.imem_addr);

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset(input logic [15:0] start);
        exp_addr   = start;
        stall_prev = 1'b0;
        pend_prev  = 1'b0;
        mem_wait   = 0;
        mem_lat    = $urandom_range(lat_hi, lat_lo);
    endtask

    task automatic do_reset(input logic [15:0] start);
        reset         = 1'b1;
        pc_write      = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        bus.imem_ack  = 1'b0;
        bus.imem_rdata = 16'h0000;
        repeat (2) begin @(posedge clock); #1; end
        check("rst_valid", fetch_valid, 1'b0);
        check("rst_instr", instruction_out, 16'h0000);
        check("rst_addr", instr_addr_out, 16'h0000);
        check("rst_req", bus.imem_req, 1'b0);
        check("rst_error", fetch_error, 1'b0);
        reset = 1'b0;
        model_reset(start);
    endtask

    // One clock cycle: check registered outputs against the model, answer the memory port,
    // then advance the model by what the coming edge must do.
    task automatic run_cycle(input bit pw, input bit br, input logic [15:0] tgt);
        bit ack;
        if (!fetch_valid) begin
            check("nop_instr", instruction_out, 16'h0000);
            check("nop_addr", instr_addr_out, 16'h0000);
        end else begin
            check("out_addr", instr_addr_out, exp_addr);
            check("out_instr", instruction_out, mem_word(exp_addr));
        end
        if (stall_prev) check("stall_valid", fetch_valid, 1'b1);
        if (pend_prev) begin
`ifndef IF_FETCH_TIMEOUT_EN
            check("req_held", bus.imem_req, 1'b1);
`endif
            if (bus.imem_req) check("addr_stable", bus.imem_addr, mem_addr_q);
        end
        ack = 1'b0;
        if (bus.imem_req) begin
            if (!pend_prev) mem_addr_q = bus.imem_addr;
            ack = (mem_wait >= mem_lat);
        end
        pc_write       = pw;
        branch_taken   = br;
        branch_target  = tgt;
        bus.imem_ack   = ack;
        bus.imem_rdata = ack ? mem_word(mem_addr_q) : 16'hDEAD;
        #1;
        check("if_flush", if_flush, br);
        if (fetch_valid && pw && !br) begin
            consumed++;
            exp_addr = exp_addr + 16'd1;
        end
        if (br) exp_addr = tgt;
        stall_prev = fetch_valid && !pw && !br;
        pend_prev  = bus.imem_req && !ack;
        if (ack) begin
            mem_wait = 0;
            mem_lat  = $urandom_range(lat_hi, lat_lo);
        end else if (bus.imem_req) begin
            mem_wait++;
        end
        @(posedge clock); #1;
        bus.imem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Back-to-back stream with same-cycle ack; wrap-around instance runs alongside.
        lat_lo = 0; lat_hi = 0;
        do_reset(16'h0000);
        run_cycle(1, 0, 16'h0000);
        check("t1_req", bus.imem_req, 1'b1);
        check("t1_req_addr", bus.imem_addr, 16'h0000);
        check("t1_valid_low", fetch_valid, 1'b0);
        run_cycle(1, 0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            check("t1_valid", fetch_valid, 1'b1);
            check("t1_seq", instr_addr_out, 16'(i));
            check("t4_wrap_valid", w_valid, 1'b1);
            check("t4_wrap_addr", w_addr, wrap_exp[i]);
            check("t4_wrap_instr", w_instr, mem_word(wrap_exp[i]));
            check("t4_wrap_flags", {w_flush, w_error}, 2'b00);
            run_cycle(1, 0, 16'h0000);
        end

        // Late ack while stalled: skid fills, request drops in HOLD, then resume in order.
        lat_lo = 2; lat_hi = 2; mem_lat = 2;
        for (int i = 0; i < 3; i++) begin
            check("t2_frozen", instr_addr_out, 16'h0003);
            run_cycle(0, 0, 16'h0000);
        end
        check("t2_hold_req", bus.imem_req, 1'b0);
        check("t2_hold_valid", fetch_valid, 1'b1);
        check("t2_hold_addr", instr_addr_out, 16'h0003);
        run_cycle(1, 0, 16'h0000);
        check("t2_resume_valid", fetch_valid, 1'b1);
        check("t2_resume_addr", instr_addr_out, 16'h0004);

        // Redirect during an outstanding request: flush, NOP, drain, refetch at target.
        lat_lo = 3; lat_hi = 3; mem_lat = 3;
        run_cycle(1, 0, 16'h0000);
        check("t3_pending_req", bus.imem_req, 1'b1);
        check("t3_pending_addr", bus.imem_addr, 16'h0005);
        run_cycle(1, 1, 16'h0040);
        check("t3_nop_valid", fetch_valid, 1'b0);
        check("t3_nop_instr", instruction_out, 16'h0000);
        check("t3_drain_addr", bus.imem_addr, 16'h0005);
        run_cycle(1, 0, 16'h0000);
        run_cycle(1, 0, 16'h0000);
        check("t3_dropped", fetch_valid, 1'b0);
        check("t3_new_req", bus.imem_req, 1'b1);
        check("t3_new_addr", bus.imem_addr, 16'h0040);

        // Randomized traffic: stalls, redirects and 0..3 cycle memory latency.
        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 400; i++) begin
            pw_r = ($urandom_range(3, 0) != 0);
            br_r = ($urandom_range(19, 0) == 0);
            run_cycle(pw_r, br_r, 16'($urandom));
        end
        check("rand_progress", consumed >= 40, 1'b1);
        check("rand_no_error", fetch_error, 1'b0);

        // Memory that never answers.
        lat_lo = 1000; lat_hi = 1000;
        do_reset(16'h0000);
        run_cycle(1, 0, 16'h0000);
`ifdef IF_FETCH_TIMEOUT_EN
        for (int k = 0; k < TIMEOUT; k++) begin
            check("t5_req_high", bus.imem_req, 1'b1);
            check("t5_addr", bus.imem_addr, 16'h0000);
            run_cycle(1, 0, 16'h0000);
        end
        check("t5_gap_req", bus.imem_req, 1'b0);
        check("t5_error", fetch_error, 1'b1);
        run_cycle(1, 0, 16'h0000);
        check("t5_rereq", bus.imem_req, 1'b1);
        check("t5_rereq_addr", bus.imem_addr, 16'h0000);
        check("t5_sticky", fetch_error, 1'b1);
`else
        for (int k = 0; k < 2 * TIMEOUT; k++) begin
            check("t5_req_held", bus.imem_req, 1'b1);
            check("t5_addr", bus.imem_addr, 16'h0000);
            check("t5_no_error", fetch_error, 1'b0);
            run_cycle(1, 0, 16'h0000);
        end
`endif

        // Reset mid-request with a late ack: ignored, refetch from RESET_PC.
        lat_lo = 0; lat_hi = 0;
        do_reset(16'h0000);
        for (int i = 0; i < 6; i++) run_cycle(1, 0, 16'h0000);
        mem_lat = 3;
        run_cycle(1, 0, 16'h0000);
        check("t6_mid_req", bus.imem_req, 1'b1);
        reset          = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hBEEF;
        @(posedge clock); #1;
        check("t6_req_dropped", bus.imem_req, 1'b0);
        check("t6_valid", fetch_valid, 1'b0);
        check("t6_instr", instruction_out, 16'h0000);
        check("t6_addr", instr_addr_out, 16'h0000);
        reset = 1'b0;
        @(posedge clock); #1;
        bus.imem_ack = 1'b0;
        check("t6_late_ack_ignored", fetch_valid, 1'b0);
        check("t6_refetch_req", bus.imem_req, 1'b1);
        check("t6_refetch_addr", bus.imem_addr, 16'h0000);
        model_reset(16'h0000);
        run_cycle(1, 0, 16'h0000);
        check("t6_first_valid", fetch_valid, 1'b1);
        check("t6_first_addr", instr_addr_out, 16'h0000);
        for (int i = 0; i < 4; i++) run_cycle(1, 0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
